// File: rtl/ym_mix_pkg.sv
// Shared types and helpers for the ym_mix multi-channel FM output mixer.
package ym_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mix_state_e;

  localparam int SAT_W = 64;

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Wide enough for CH_COUNT full-scale products, so the sum never wraps.
  function automatic int acc_width(input int in_w, input int gain_w, input int ch_count);
    return in_w + gain_w + 1 + $clog2(ch_count);
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ym_mix_pdm.sv
// First-order delta-sigma modulator for one output side; the module only
// exists when YM_MIX_PDM_EN is defined, matching its single use in the top.
`ifdef YM_MIX_PDM_EN
module ym_mix_pdm #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         pdm
);

  logic [W:0] acc_q, acc_d;

  // The carry out of the W-bit phase accumulator is the output bit.
  always_comb acc_d = {1'b0, acc_q[W-1:0]} + {1'b0, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign pdm = acc_q[W];

endmodule
`endif

// File: rtl/ym_mix_engine.sv
// Sequential stereo mixer: one channel per clock, per-channel gain and mute,
// saturated output with sticky flags. Optional PDM outputs via YM_MIX_PDM_EN.
module ym_mix_engine
  import ym_mix_pkg::*;
#(
  parameter int CH_COUNT = 4,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int GAIN_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_stb,
  input  logic [CH_COUNT*IN_W-1:0]   in_left,
  input  logic [CH_COUNT*IN_W-1:0]   in_right,
  input  logic [CH_COUNT-1:0]        mute,
  input  logic                       gain_we,
  input  logic [4:0]                 gain_addr,
  input  logic [GAIN_W-1:0]          gain_din,
  input  logic                       clip_clr,
  output logic signed [OUT_W-1:0]    out_left,
  output logic signed [OUT_W-1:0]    out_right,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       clip_l,
  output logic                       clip_r,
  output logic                       overrun,
  output logic                       pdm_left,
  output logic                       pdm_right
);

  localparam int ACC_W  = acc_width(IN_W, GAIN_W, CH_COUNT);
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int IDX_W  = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CH_COUNT - 1);
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_W));

  mix_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [CH_COUNT*GAIN_W-1:0]  gain_q, gain_d, snap_gain_q, snap_gain_d;
  logic [CH_COUNT*IN_W-1:0]    snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic [CH_COUNT-1:0]         snap_mute_q, snap_mute_d;
  logic signed [OUT_W-1:0]     out_l_q, out_l_d, out_r_q, out_r_d;
  logic                        valid_q, valid_d;
  logic                        clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic                        overrun_q, overrun_d;

  logic signed [IN_W-1:0]      cur_l, cur_r;
  logic [GAIN_W-1:0]           cur_gain;
  logic signed [PROD_W-1:0]    gain_ext, prod_l, prod_r;
  logic signed [ACC_W-1:0]     shift_l, shift_r;
  logic signed [SAT_W-1:0]     sat_l, sat_r;
  logic                        sat_hit_l, sat_hit_r;

  // Datapath: signed sample times zero-extended gain, then the DONE-stage scaling.
  always_comb begin
    cur_l    = snap_l_q[idx_q*IN_W +: IN_W];
    cur_r    = snap_r_q[idx_q*IN_W +: IN_W];
    cur_gain = snap_gain_q[idx_q*GAIN_W +: GAIN_W];
    gain_ext = PROD_W'({1'b0, cur_gain});
    if (snap_mute_q[idx_q]) begin
      prod_l = '0;
      prod_r = '0;
    end else begin
      prod_l = PROD_W'(cur_l) * gain_ext;
      prod_r = PROD_W'(cur_r) * gain_ext;
    end
    shift_l   = acc_l_q >>> (GAIN_W - 1);
    shift_r   = acc_r_q >>> (GAIN_W - 1);
    sat_l     = saturate(SAT_W'(shift_l), OUT_W);
    sat_r     = saturate(SAT_W'(shift_r), OUT_W);
    sat_hit_l = (sat_l != SAT_W'(shift_l));
    sat_hit_r = (sat_r != SAT_W'(shift_r));
  end

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    snap_l_d    = snap_l_q;
    snap_r_d    = snap_r_q;
    snap_mute_d = snap_mute_q;
    snap_gain_d = snap_gain_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    valid_d     = 1'b0;
    clip_l_d    = clip_clr ? 1'b0 : clip_l_q;
    clip_r_d    = clip_clr ? 1'b0 : clip_r_q;
    overrun_d   = clip_clr ? 1'b0 : overrun_q;

    gain_d = gain_q;
    if (gain_we && (gain_addr < 5'(CH_COUNT)))
      gain_d[gain_addr*GAIN_W +: GAIN_W] = gain_din;

    unique case (state_q)
      IDLE: begin
        if (sample_stb) begin
          snap_l_d    = in_left;
          snap_r_d    = in_right;
          snap_mute_d = mute;
          snap_gain_d = gain_q;
          acc_l_d     = '0;
          acc_r_d     = '0;
          idx_d       = '0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        acc_l_d = acc_l_q + ACC_W'(prod_l);
        acc_r_d = acc_r_q + ACC_W'(prod_r);
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + IDX_W'(1);
        if (sample_stb) overrun_d = 1'b1;
      end
      DONE: begin
        out_l_d = sat_l[OUT_W-1:0];
        out_r_d = sat_r[OUT_W-1:0];
        valid_d = 1'b1;
        if (sat_hit_l)  clip_l_d  = 1'b1;
        if (sat_hit_r)  clip_r_d  = 1'b1;
        if (sample_stb) overrun_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers update with <= so every flop samples pre-edge values together.
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      gain_q    <= {CH_COUNT{UNITY}};
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      gain_q    <= gain_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      valid_q   <= valid_d;
      clip_l_q  <= clip_l_d;
      clip_r_q  <= clip_r_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: snapshot storage has no reset; it is always loaded on sample_stb before ACCUM reads it.
  always_ff @(posedge clk) begin
    snap_l_q    <= snap_l_d;
    snap_r_q    <= snap_r_d;
    snap_mute_q <= snap_mute_d;
    snap_gain_q <= snap_gain_d;
  end

  assign out_left  = out_l_q;
  assign out_right = out_r_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign overrun   = overrun_q;

`ifdef YM_MIX_PDM_EN
  // Offset-binary input: flipping the MSB maps -2^(OUT_W-1) to 0.
  ym_mix_pdm #(.W(OUT_W)) u_pdm_left (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({~out_l_q[OUT_W-1], out_l_q[OUT_W-2:0]}),
    .pdm   (pdm_left)
  );

  ym_mix_pdm #(.W(OUT_W)) u_pdm_right (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({~out_r_q[OUT_W-1], out_r_q[OUT_W-2:0]}),
    .pdm   (pdm_right)
  );
`else
  assign pdm_left  = 1'b0;
  assign pdm_right = 1'b0;
`endif

endmodule

// File: tb/tb_ym_mix_engine.sv
// Self-checking bench for ym_mix_engine: directed steps plus randomized frames
// against an arithmetic reference model of the mixing rules.
module tb_ym_mix_engine;

  localparam int CH     = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 16;
  localparam int GAIN_W = 8;
  localparam longint UNITY_DIV = 128;
  localparam longint OUT_MAX   = 32767;
  localparam longint OUT_MIN   = -32768;

  logic                     clk;
  logic                     rst_n;
  logic                     sample_stb;
  logic [CH*IN_W-1:0]       in_left;
  logic [CH*IN_W-1:0]       in_right;
  logic [CH-1:0]            mute;
  logic                     gain_we;
  logic [4:0]               gain_addr;
  logic [GAIN_W-1:0]        gain_din;
  logic                     clip_clr;
  logic signed [OUT_W-1:0]  out_left;
  logic signed [OUT_W-1:0]  out_right;
  logic                     out_valid;
  logic                     busy;
  logic                     clip_l;
  logic                     clip_r;
  logic                     overrun;
  logic                     pdm_left;
  logic                     pdm_right;

  ym_mix_engine #(
    .CH_COUNT (CH),
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .GAIN_W   (GAIN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_stb (sample_stb),
    .in_left    (in_left),
    .in_right   (in_right),
    .mute       (mute),
    .gain_we    (gain_we),
    .gain_addr  (gain_addr),
    .gain_din   (gain_din),
    .clip_clr   (clip_clr),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .busy       (busy),
    .clip_l     (clip_l),
    .clip_r     (clip_r),
    .overrun    (overrun),
    .pdm_left   (pdm_left),
    .pdm_right  (pdm_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_fail  = 0;

  // Reference model state: frame inputs, live gains, sticky flags.
  int          sl[CH];
  int          sr[CH];
  logic [CH-1:0] sm;
  int          gm[CH];
  bit          exp_clip_l, exp_clip_r, exp_ovr;
  longint      exp_l, exp_r;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint mix_raw(input bit right);
    longint sum = 0;
    for (int i = 0; i < CH; i++)
      if (!sm[i]) sum += longint'(right ? sr[i] : sl[i]) * longint'(gm[i]);
    return floor_div(sum, UNITY_DIV);
  endfunction

  function automatic longint clamp(input longint v);
    if (v > OUT_MAX) return OUT_MAX;
    if (v < OUT_MIN) return OUT_MIN;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) gm[i] = 128;
    exp_clip_l = 0;
    exp_clip_r = 0;
    exp_ovr    = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < CH; i++) begin
      in_left[i*IN_W +: IN_W]  = IN_W'(sl[i]);
      in_right[i*IN_W +: IN_W] = IN_W'(sr[i]);
    end
    mute = sm;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < CH; i++) begin
      in_left[i*IN_W +: IN_W]  = IN_W'($urandom);
      in_right[i*IN_W +: IN_W] = IN_W'($urandom);
    end
    mute = CH'($urandom);
  endtask

  task automatic predict();
    longint raw_l, raw_r;
    raw_l = mix_raw(1'b0);
    raw_r = mix_raw(1'b1);
    exp_l = clamp(raw_l);
    exp_r = clamp(raw_r);
    if (exp_l != raw_l) exp_clip_l = 1;
    if (exp_r != raw_r) exp_clip_r = 1;
  endtask

  task automatic write_gain(input int addr, input int val);
    @(negedge clk);
    gain_we   = 1'b1;
    gain_addr = 5'(addr);
    gain_din  = GAIN_W'(val);
    @(negedge clk);
    gain_we = 1'b0;
    if (addr < CH) gm[addr] = val;
  endtask

  task automatic pulse_clip_clr();
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
    exp_clip_l = 0;
    exp_clip_r = 0;
    exp_ovr    = 0;
  endtask

  // One full frame; inputs are scrambled right after the strobe so the result
  // must come from the snapshot. out_valid is expected at the negedge after
  // edge E(CH+1), i.e. the (CH+2)th negedge counted from the strobe.
  task automatic run_frame(input string tag);
    int cyc;
    predict();
    @(negedge clk);
    drive_inputs();
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    check({tag, "_busy"}, busy, 1);
    scramble_inputs();
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, CH + 2);
    check({tag, "_left"},    out_left,  exp_l);
    check({tag, "_right"},   out_right, exp_r);
    check({tag, "_clip_l"},  clip_l,  exp_clip_l);
    check({tag, "_clip_r"},  clip_r,  exp_clip_r);
    check({tag, "_overrun"}, overrun, exp_ovr);
    @(negedge clk);
    check({tag, "_valid_once"}, out_valid, 0);
    check({tag, "_idle"},       busy, 0);
  endtask

  task automatic set_frame(input int l0, l1, l2, l3, input int r0, r1, r2, r3,
                           input logic [CH-1:0] m);
    sl[0] = l0; sl[1] = l1; sl[2] = l2; sl[3] = l3;
    sr[0] = r0; sr[1] = r1; sr[2] = r2; sr[3] = r3;
    sm = m;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    rst_n      = 1'b0;
    sample_stb = 1'b0;
    in_left    = '0;
    in_right   = '0;
    mute       = '0;
    gain_we    = 1'b0;
    gain_addr  = '0;
    gain_din   = '0;
    clip_clr   = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_left",  out_left, 0);
    check("rst_out_right", out_right, 0);
    check("rst_valid",     out_valid, 0);
    check("rst_busy",      busy, 0);
    check("rst_clip",      {clip_l, clip_r, overrun}, 0);
    check("rst_pdm",       {pdm_left, pdm_right}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset gains are unity: ch0 alone passes straight through
    set_frame(1000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    run_frame("rst_gain");
    check("rst_gain_const", out_left, 1000);

    // Unity sum
    set_frame(1000, 2000, -500, 0, -1, -1, -1, -1, 4'b0000);
    run_frame("unity");
    check("unity_l_const", out_left, 2500);
    check("unity_r_const", out_right, -4);

    // Saturation both ways, then clear
    set_frame(30000, 30000, 30000, 30000, 0, 0, 0, 0, 4'b0000);
    run_frame("sat_pos");
    check("sat_pos_const", out_left, 32767);
    check("sat_pos_clip",  clip_l, 1);
    set_frame(-30000, -30000, -30000, -30000, 0, 0, 0, 0, 4'b0000);
    run_frame("sat_neg");
    check("sat_neg_const", out_left, -32768);
    pulse_clip_clr();
    check("clr_flags", {clip_l, clip_r, overrun}, 0);

    // Gain scaling with floor rounding; out-of-range address ignored
    write_gain(0, 'h40);
    set_frame(1001, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    run_frame("gain_half_pos");
    check("gain_half_pos_const", out_left, 500);
    set_frame(-1001, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    run_frame("gain_half_neg");
    check("gain_half_neg_const", out_left, -501);
    write_gain(0, 'hFF);
    set_frame(256, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    run_frame("gain_max");
    check("gain_max_const", out_left, 510);
    write_gain(7, 'h00);
    run_frame("gain_addr7");
    check("gain_addr7_const", out_left, 510);

    // Mute
    write_gain(0, 'h80);
    set_frame(10, 5000, 0, 0, 0, 7, 0, 0, 4'b0010);
    run_frame("mute");
    check("mute_const", out_left, 10);

    // Overrun: a second strobe two cycles into the frame is ignored
    set_frame(111, 222, 0, 0, 3, 0, 0, 0, 4'b0000);
    predict();
    @(negedge clk);
    drive_inputs();
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    @(negedge clk);
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    exp_ovr = 1;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) begin
        nv++;
        check("ovr_left", out_left, exp_l);
      end
      @(negedge clk);
    end
    check("ovr_valid_count", nv, 1);
    check("ovr_flag", overrun, 1);
    pulse_clip_clr();
    check("ovr_cleared", overrun, 0);

    // Reset in the middle of ACCUM (idx=2): frame abandoned, nothing emitted
    set_frame(4000, 4000, 4000, 4000, 1, 1, 1, 1, 4'b0000);
    write_gain(1, 'h10);
    @(negedge clk);
    drive_inputs();
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_busy",  busy, 0);
    check("midrst_left",  out_left, 0);
    check("midrst_right", out_right, 0);
    check("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst_no_valid", nv, 0);
    set_frame(1000, 1000, 0, 0, 0, 0, 0, 0, 4'b0000);
    run_frame("post_rst");

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 1) == 1) write_gain(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) write_gain(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) pulse_clip_clr();
      for (int i = 0; i < CH; i++) begin
        sl[i] = int'($signed(16'($urandom)));
        sr[i] = (f < 8) ? int'($signed(16'($urandom))) >>> 4 : int'($signed(16'($urandom)));
      end
      sm = CH'($urandom);
      run_frame($sformatf("rand%0d", f));
    end

`ifdef YM_MIX_PDM_EN
    // With out_* = 0 the offset input is mid-scale: exactly half the bits set
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int ones_l, ones_r;
      ones_l = 0;
      ones_r = 0;
      for (int i = 0; i < 1024; i++) begin
        @(negedge clk);
        ones_l += int'(pdm_left);
        ones_r += int'(pdm_right);
      end
      check("pdm_density_l", ones_l, 512);
      check("pdm_density_r", ones_r, 512);
    end
`else
    check("pdm_tied_low", {pdm_left, pdm_right}, 0);
`endif

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
